hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage RV32 core. It watches the ID-stage operand addresses and the EX-stage destination and control bits, and drives the stall, flush and hold controls that the IF/ID and ID/EX registers and the PC consume. It resolves load-use hazards, taken-branch redirects and multi-cycle mul/div occupancy of EX.

---
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and mul/div occupancy of EX.
// Optional HAZARD_PERF_CNT_EN adds a stall_cycles counter of cycles with PCWrite low.
module hazard_ctrl #(
  parameter int unsigned MDU_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic        MemRead_ex,
  input  logic [4:0]  rdAddr_ex,
  input  logic [4:0]  rs1Addr_id,
  input  logic [4:0]  rs2Addr_id,
  input  logic        rs1Used_id,
  input  logic        rs2Used_id,
  input  logic        MulDiv_id,
  input  logic        mdu_done,
  input  logic        BranchTaken_ex,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        ID_EX_Hold,
  output logic        mdu_start,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] stall_cycles,
`endif
  output logic        mdu_error
);

  localparam int unsigned TimerW = 8;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(MDU_TIMEOUT - 1);
  localparam logic [TimerW-1:0] TimerMax  = {TimerW{1'b1}};

  typedef enum logic [0:0] {RUN, MDU_BUSY} state_e;

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                start_q, start_d;
  logic                load_use_c;

  assign load_use_c = MemRead_ex && (rdAddr_ex != 5'd0) &&
                      ((rs1Used_id && (rs1Addr_id == rdAddr_ex)) ||
                       (rs2Used_id && (rs2Addr_id == rdAddr_ex)));

  assign mdu_start = start_q;

  // Next state and pipeline controls; reset forces the bubble/hold-PC pattern asynchronously.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    start_d     = 1'b0;
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    ID_EX_Hold  = 1'b0;
    mdu_error   = 1'b0;
    if (!Reset_n) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      state_d     = RUN;
      timer_d     = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (BranchTaken_ex) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
          end else if (load_use_c) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
          end else if (MulDiv_id) begin
            state_d = MDU_BUSY;
            timer_d = '0;
            start_d = 1'b1;
          end
        end
        MDU_BUSY: begin
          // EX owns the mul/div op here, so branch and load-use inputs are not considered.
          if (mdu_done) begin
            state_d = RUN;
          end else if (timer_q == TimerLast) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
            mdu_error   = 1'b1;
            state_d     = RUN;
          end else begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Hold  = 1'b1;
            timer_d     = (timer_q == TimerMax) ? timer_q : timer_q + TimerW'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= RUN;
      timer_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      start_q <= start_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Wrapping count of cycles in which the PC was held.
  always_comb begin
    stall_d = stall_q;
    if (!PCWrite) stall_d = stall_q + 32'(1);
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MDU_TIMEOUT=8).
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        Reset_n;
  logic        MemRead_ex;
  logic [4:0]  rdAddr_ex, rs1Addr_id, rs2Addr_id;
  logic        rs1Used_id, rs2Used_id, MulDiv_id, mdu_done, BranchTaken_ex;
  logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, ID_EX_Hold, mdu_start, mdu_error;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int passed = 0;
  int exp_stall = 0;

  hazard_ctrl #(.MDU_TIMEOUT(8)) dut (
    .clk(clk), .Reset_n(Reset_n), .MemRead_ex(MemRead_ex), .rdAddr_ex(rdAddr_ex),
    .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id), .rs1Used_id(rs1Used_id),
    .rs2Used_id(rs2Used_id), .MulDiv_id(MulDiv_id), .mdu_done(mdu_done),
    .BranchTaken_ex(BranchTaken_ex), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush), .ID_EX_Hold(ID_EX_Hold),
    .mdu_start(mdu_start),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .mdu_error(mdu_error)
  );

  always #5 clk = ~clk;

  // Observed controls packed as {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, ID_EX_Hold, mdu_start, mdu_error}.
  function automatic logic [6:0] outs();
    return {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, ID_EX_Hold, mdu_start, mdu_error};
  endfunction

  function automatic logic [20:0] mk(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                                     input logic [4:0] r2, input logic u1, input logic u2,
                                     input logic md, input logic dn, input logic br);
    return {mr, rd, r1, r2, u1, u2, md, dn, br};
  endfunction

  task automatic drive(input logic [20:0] v);
    @(negedge clk);
    {MemRead_ex, rdAddr_ex, rs1Addr_id, rs2Addr_id, rs1Used_id, rs2Used_id,
     MulDiv_id, mdu_done, BranchTaken_ex} = v;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    {MemRead_ex, rdAddr_ex, rs1Addr_id, rs2Addr_id, rs1Used_id, rs2Used_id,
     MulDiv_id, mdu_done, BranchTaken_ex} = '0;
    #12;
    checks++;
    if (outs() !== 7'b0011000) $display("FAIL reset_outs got=%b exp=%b", outs(), 7'b0011000);
    else passed++;
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cycles !== 32'd0) $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cycles);
    else passed++;
`endif
    @(negedge clk);
    Reset_n = 1'b1;
    exp_stall = 0;
  endtask

  task automatic test_load_use();
    logic [20:0] vi [4];
    logic [6:0]  ve [4];
    vi = '{mk(1,5,5,0,1,0,0,0,0), mk(0,5,5,0,1,0,0,0,0), mk(1,7,0,7,0,1,0,0,0), mk(1,7,0,7,1,0,0,0,0)};
    ve = '{7'b0001000, 7'b1100000, 7'b0001000, 7'b1100000};
    for (int i = 0; i < 4; i++) begin
      drive(vi[i]);
      #1;
      checks++;
      if (outs() !== ve[i]) $display("FAIL load_use[%0d] got=%b exp=%b", i, outs(), ve[i]);
      else passed++;
      if (!ve[i][6]) exp_stall++;
    end
  endtask

  task automatic test_no_hazard();
    logic [20:0] vi [3];
    logic [6:0]  ve [3];
    vi = '{mk(1,0,0,0,1,1,0,0,0), mk(1,5,3,5,1,0,0,0,0), mk(0,5,5,5,1,1,0,0,0)};
    ve = '{7'b1100000, 7'b1100000, 7'b1100000};
    for (int i = 0; i < 3; i++) begin
      drive(vi[i]);
      #1;
      checks++;
      if (outs() !== ve[i]) $display("FAIL no_hazard[%0d] got=%b exp=%b", i, outs(), ve[i]);
      else passed++;
    end
  endtask

  task automatic test_branch();
    logic [20:0] vi [3];
    logic [6:0]  ve [3];
    vi = '{mk(1,5,5,0,1,0,0,0,1), mk(0,0,0,0,0,0,1,0,1), mk(0,0,0,0,0,0,0,0,0)};
    ve = '{7'b1111000, 7'b1111000, 7'b1100000};
    for (int i = 0; i < 3; i++) begin
      drive(vi[i]);
      #1;
      checks++;
      if (outs() !== ve[i]) $display("FAIL branch[%0d] got=%b exp=%b", i, outs(), ve[i]);
      else passed++;
    end
  endtask

  task automatic test_mdu();
    logic [20:0] vi [6];
    logic [6:0]  ve [6];
    vi = '{mk(0,0,0,0,0,0,1,0,0), mk(0,0,0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0,0,1),
           mk(1,5,5,0,1,0,0,0,0), mk(0,0,0,0,0,0,0,1,0), mk(0,0,0,0,0,0,0,0,0)};
    ve = '{7'b1100000, 7'b0000110, 7'b0000100, 7'b0000100, 7'b1100000, 7'b1100000};
    for (int i = 0; i < 6; i++) begin
      drive(vi[i]);
      #1;
      checks++;
      if (outs() !== ve[i]) $display("FAIL mdu[%0d] got=%b exp=%b", i, outs(), ve[i]);
      else passed++;
      if (!ve[i][6]) exp_stall++;
    end
  endtask

  task automatic test_mdu_fast();
    logic [20:0] vi [3];
    logic [6:0]  ve [3];
    vi = '{mk(0,0,0,0,0,0,1,0,0), mk(0,0,0,0,0,0,0,1,0), mk(0,0,0,0,0,0,0,0,0)};
    ve = '{7'b1100000, 7'b1100010, 7'b1100000};
    for (int i = 0; i < 3; i++) begin
      drive(vi[i]);
      #1;
      checks++;
      if (outs() !== ve[i]) $display("FAIL mdu_fast[%0d] got=%b exp=%b", i, outs(), ve[i]);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    logic [6:0] e;
    for (int i = 0; i < 10; i++) begin
      drive(mk(0,0,0,0,0,0, (i == 0), 0, 0));
      if (i == 0)      e = 7'b1100000;
      else if (i == 1) e = 7'b0000110;
      else if (i < 8)  e = 7'b0000100;
      else if (i == 8) e = 7'b0001001;
      else             e = 7'b1100000;
      #1;
      checks++;
      if (outs() !== e) $display("FAIL timeout[%0d] got=%b exp=%b", i, outs(), e);
      else passed++;
      if (!e[6]) exp_stall++;
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_cnt();
    drive(mk(0,0,0,0,0,0,0,0,0));
    #1;
    checks++;
    if (stall_cycles !== 32'(exp_stall)) $display("FAIL stall_cnt got=%0d exp=%0d", stall_cycles, exp_stall);
    else passed++;
  endtask
`endif

  task automatic test_reset_mid();
    logic [6:0] ve [3];
    ve = '{7'b1100000, 7'b0000110, 7'b0000100};
    for (int i = 0; i < 3; i++) begin
      drive(mk(0,0,0,0,0,0, (i == 0), 0, 0));
      #1;
      checks++;
      if (outs() !== ve[i]) $display("FAIL reset_mid_busy[%0d] got=%b exp=%b", i, outs(), ve[i]);
      else passed++;
    end
    #2;
    Reset_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 7'b0011000) $display("FAIL reset_mid_async got=%b exp=%b", outs(), 7'b0011000);
    else passed++;
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cycles !== 32'd0) $display("FAIL reset_mid_stall_cnt got=%0d exp=0", stall_cycles);
    else passed++;
`endif
    @(posedge clk);
    @(negedge clk);
    Reset_n = 1'b1;
    #1;
    checks++;
    if (outs() !== 7'b1100000) $display("FAIL reset_mid_run got=%b exp=%b", outs(), 7'b1100000);
    else passed++;
    exp_stall = 0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
    test_mdu();
    test_mdu_fast();
    test_timeout();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_cnt();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
